// File: rtl/exp_float_to_fixed_if.sv
// exp_float_to_fixed_if: valid/ready request and result bundle for the float-to-fixed converter.
interface exp_float_to_fixed_if;
   logic [31:0] in_float32;
   logic in_valid;
   logic in_ready;
   logic [7:0] out_fixed_int;
   logic [22:0] out_fixed_frac;
   logic out_ovf;
   logic out_unf;
   logic out_valid;
   logic out_ready;
   modport master (
      output in_float32, in_valid, out_ready,
      input in_ready, out_fixed_int, out_fixed_frac, out_ovf, out_unf, out_valid
   );
   modport slave (
      input in_float32, in_valid, out_ready,
      output in_ready, out_fixed_int, out_fixed_frac, out_ovf, out_unf, out_valid
   );
endinterface

// File: rtl/exp_float_to_fixed.sv
// exp_float_to_fixed: splits a float32 into floor(x) (signed 8b) and a 23b fraction, one shift per cycle.
module exp_float_to_fixed (
   input logic clk,
   input logic rst,
   exp_float_to_fixed_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, FIX = 2'd2, DONE = 2'd3;
   logic [1:0] state;
   logic sgn, left, f_ovf, f_unf;
   logic [4:0] cnt, ld_cnt;
   logic [30:0] mag, q;
   logic [7:0] e;
   logic [22:0] m;
   logic s, nan, big, r_ovf, r_unf;
   logic signed [7:0] qi;
   assign bus.in_ready = (state == IDLE) && !rst;
   always_comb begin
      s = bus.in_float32[31];
      e = bus.in_float32[30:23];
      m = bus.in_float32[22:0];
      nan = (e == 8'hFF) && (m != 23'd0);
      big = e >= 8'd134;
      ld_cnt = (e >= 8'd128 && e <= 8'd133) ? 5'(e - 8'd127) :
               (e >= 8'd104 && e <= 8'd126) ? 5'(8'd127 - e) : 5'd0;
      // 31-bit negation keeps the low bits of the 32-bit two's complement value
      q = sgn ? -mag : mag;
      qi = q[30:23];
      r_ovf = f_ovf || (!f_unf && qi > 8'sd88);
      r_unf = f_unf || (!f_ovf && qi < -8'sd103);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sgn <= 1'b0;
         left <= 1'b0;
         f_ovf <= 1'b0;
         f_unf <= 1'b0;
         cnt <= 5'd0;
         mag <= 31'd0;
         bus.out_fixed_int <= 8'd0;
         bus.out_fixed_frac <= 23'd0;
         bus.out_ovf <= 1'b0;
         bus.out_unf <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               sgn <= s;
               left <= e > 8'd127;
               mag <= (e <= 8'd103) ? 31'd0 : {7'd0, 1'b1, m};
               cnt <= ld_cnt;
               f_ovf <= nan || (big && !s);
               f_unf <= !nan && big && s;
               state <= (ld_cnt == 5'd0) ? FIX : SHIFT;
            end
            SHIFT: begin
               mag <= left ? mag << 1 : mag >> 1;
               cnt <= cnt - 5'd1;
               state <= (cnt == 5'd1) ? FIX : SHIFT;
            end
            FIX: begin
               bus.out_fixed_int <= r_ovf ? 8'h7F : r_unf ? 8'h80 : qi;
               bus.out_fixed_frac <= (r_ovf || r_unf) ? 23'd0 : q[22:0];
               bus.out_ovf <= r_ovf;
               bus.out_unf <= r_unf;
               bus.out_valid <= 1'b1;
               state <= DONE;
            end
            default: if (bus.out_ready) begin
               bus.out_valid <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/exp_float_to_fixed.md
# exp_float_to_fixed

Iterative float32-to-fixed-point converter that sits in front of the exponent lookup path. It splits an IEEE-754 single x into a signed 8-bit integer part floor(x) and a 23-bit fraction x − floor(x). It classifies x against the table range [−103, 88], and when x is out of range it drives saturated integer codes that the lookup stage maps to +inf or 0. Input and output use valid/ready handshakes, and the shifter moves one bit per cycle.

## Interface
- num_of_int, 8, integer-part width (signed); fixed.
- FRAC_BITS, 23, fraction width; fixed.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_FLOAT32  in  32  IEEE-754 single x.
- IN_VALID  in  1  IN_FLOAT32 is valid.
- IN_READY  out  1  converter can accept input.
- OUT_FIXED_INT  out  8  floor(x), two's complement.
- OUT_FIXED_FRAC  out  23  fractional part, unsigned, LSB = 2^-23.
- OUT_OVF  out  1  x ≥ 89, +inf or NaN.
- OUT_UNF  out  1  floor(x) < −103 or −inf.
- OUT_VALID  out  1  outputs valid.
- OUT_READY  in  1  downstream accepts the result.

## Operation
- **States:**
  - IDLE: IN_READY=1. Accepts on IN_VALID & IN_READY.
  - SHIFT: shifts the magnitude one bit per cycle.
  - FIX: negates and range-checks.
  - DONE: holds the result until it is taken.
- **Capture:** on the accept edge, latch sign s, exponent e and mantissa {1,m}. Load the 31-bit magnitude register M = {1,m} and set the shift count n.
  - e = 255 with m ≠ 0 (NaN): OVF, n=0.
  - e = 255 with m = 0: s=0 gives OVF, s=1 gives UNF. n=0.
  - e ≥ 134 (|x| ≥ 128): s=0 gives OVF, s=1 gives UNF. n=0.
  - 128 ≤ e ≤ 133: left shift, n = e − 127.
  - e = 127: n=0.
  - 104 ≤ e ≤ 126: right shift, n = 127 − e. Bits shifted out are dropped (truncation).
  - e ≤ 103 (including zero and denormals): M = 0, n = 0.
- **SHIFT:** one shift per cycle until n reaches 0, then go to FIX. If n=0 at capture, go directly to FIX.
- **FIX:**
  - Q = s ? −M : M, 32-bit two's complement.
  - int = Q[30:23] (arithmetic), frac = Q[22:0]. Negative values therefore floor, with a non-negative fraction.
  - Range check: int ≥ 89 gives OVF; int < −103 gives UNF.
- **Output encoding:** in-range results drive the int/frac values above. OVF drives int = 0x7F, frac = 0. UNF drives int = 0x80, frac = 0. Exactly one of OVF/UNF is set, or neither.
- **DONE:** OUT_VALID=1. Outputs stay stable while OUT_READY=0. On OUT_VALID & OUT_READY, go to IDLE.

## Timing
- **Reset:**
  - State IDLE.
  - OUT_VALID=0, OUT_FIXED_INT=0, OUT_FIXED_FRAC=0, OUT_OVF=0, OUT_UNF=0.
  - IN_READY=0 while RST is high, 1 from the first cycle after.
- **Latency:** OUT_VALID rises n+1 cycles after the accepting edge. Minimum is 1 (n=0); maximum is 24 (e=104, n=23).
- **IN_READY:** equals state==IDLE. IN_VALID is ignored in all other states; there is no input buffering.
- **Output handshake:** OUT_VALID falls the cycle after the OUT_VALID & OUT_READY edge. IN_READY is 1 in that same cycle. Minimum period is n+3 cycles per result.
- **Reset mid-operation:** RST high in any state aborts the conversion. The result is discarded and all outputs take reset values on that edge.
- **RST with IN_VALID:** RST takes priority; no capture occurs.
- **IN_FLOAT32:** sampled only on the accept edge; later changes have no effect.

## Test plan
- 0x3F800000 (1.0) → int 0x01, frac 0, no flags. OUT_VALID 1 cycle after accept.
- 0xBF000000 (−0.5) → int 0xFF, frac 0x400000, no flags. OUT_VALID 2 cycles after accept.
- Upper bound:
  - 0x42B10000 (88.5) → int 0x58, frac 0x400000, no flags, latency 7.
  - 0x42B20000 (89.0) → OVF=1, int 0x7F, frac 0.
- Lower bound:
  - 0xC2CE0000 (−103.0) → int 0x99, frac 0, no flags.
  - 0xC2CF0000 (−103.5) → floor −104 → UNF=1, int 0x80.
- Special values:
  - 0x7FC00000 → OVF.
  - 0xFF800000 → UNF.
  - 0x00000001 → int 0, frac 0, no flags, latency 1.
  - 0x33800000 (2^−24) → int 0, frac 0, latency 1.
- Backpressure and reset:
  - Hold OUT_READY=0 for 5 cycles in DONE, pulsing IN_VALID with new data. Outputs must be unchanged, IN_READY=0, and no capture occurs.
  - Assert RST during SHIFT for 0x42B10000. All outputs 0 and state IDLE the next cycle. A following 1.0 converts correctly.
